// File: rtl/ysyx_22050598_exu_muldiv_ctrl.sv
// ysyx_22050598_exu_muldiv_ctrl: sequences one mul/div op through the iterative unit, with flush and a hang watchdog
module ysyx_22050598_exu_muldiv_ctrl #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_mul,
  input  logic            ex_is_div,
  input  logic [1:0]      ex_res_sel,
  input  logic            ex_muldivw,
  input  logic [1:0]      ex_mul_signed,
  input  logic            ex_div_signed,
  input  logic [XLEN-1:0] ex_op_a,
  input  logic [XLEN-1:0] ex_op_b,
  input  logic            flush,
  input  logic            wb_ready,
  input  logic            md_ready,
  input  logic            md_out_valid,
  input  logic [XLEN-1:0] md_result_hi,
  input  logic [XLEN-1:0] md_result_lo,
  input  logic [XLEN-1:0] md_quotient,
  input  logic [XLEN-1:0] md_remainder,
  output logic            md_mul_valid,
  output logic            md_div_valid,
  output logic            md_flush,
  output logic            md_muldivw,
  output logic [1:0]      md_mul_signed,
  output logic            md_div_signed,
  output logic [XLEN-1:0] md_rs1,
  output logic [XLEN-1:0] md_rs2,
  output logic            ex_stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            busy,
  output logic            timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic is_mul_q, is_mul_d, muldivw_q, muldivw_d, div_signed_q, div_signed_d, timeout_q, timeout_d;
  logic [1:0] res_sel_q, res_sel_d, mul_signed_q, mul_signed_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d, sel_raw, sel_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, wd_fire;
  // next-state, latch updates and all combinational outputs
  always_comb begin
    accept = state_q == IDLE && ex_valid && (ex_is_mul || ex_is_div) && !flush;
    sel_raw = res_sel_q == 2'b00 ? md_result_lo : res_sel_q == 2'b01 ? md_result_hi :
              res_sel_q == 2'b10 ? md_quotient : md_remainder;
    sel_ext = muldivw_q ? {{(XLEN-32){sel_raw[31]}}, sel_raw[31:0]} : sel_raw;
    wd_fire = !rst && state_q == WAIT && cnt_q == CNT_W'(TIMEOUT_CYCLES-1) && !md_out_valid && !flush;
    state_d = state_q;
    is_mul_d = is_mul_q;
    res_sel_d = res_sel_q;
    muldivw_d = muldivw_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    cnt_d = cnt_q;
    res_d = res_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ISSUE;
        is_mul_d = ex_is_mul;
        res_sel_d = ex_res_sel;
        muldivw_d = ex_muldivw;
        mul_signed_d = ex_mul_signed;
        div_signed_d = ex_div_signed;
        rs1_d = ex_op_a;
        rs2_d = ex_op_b;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = flush ? IDLE : md_ready ? WAIT : ISSUE;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (md_out_valid) begin
          state_d = DONE;
          cnt_d = '0;
          res_d = sel_ext;
        end else if (wd_fire) begin
          state_d = DONE;
          cnt_d = '0;
          res_d = '1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = (flush || wb_ready) ? IDLE : DONE;
    endcase
    busy = state_q != IDLE;
    md_mul_valid = state_q == ISSUE && is_mul_q && !flush;
    md_div_valid = state_q == ISSUE && !is_mul_q && !flush;
    md_flush = !rst && ((busy && flush) || wd_fire);
    ex_stall = accept || state_q == ISSUE || state_q == WAIT || (state_q == DONE && !wb_ready);
    res_valid = state_q == DONE;
    res_data = res_q;
    md_muldivw = muldivw_q;
    md_mul_signed = mul_signed_q;
    md_div_signed = div_signed_q;
    md_rs1 = rs1_q;
    md_rs2 = rs2_q;
    timeout_err = timeout_q;
  end
  // state and latch registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_mul_q <= 1'b0;
      res_sel_q <= '0;
      muldivw_q <= 1'b0;
      mul_signed_q <= '0;
      div_signed_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_mul_q <= is_mul_d;
      res_sel_q <= res_sel_d;
      muldivw_q <= muldivw_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      timeout_q <= timeout_d;
    end
  end
endmodule
